mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E stage, models fixed multi-cycle latency with an internal counter, and holds the HI/LO architectural registers for mfhi/mflo. It feeds the hazard unit: the hazard unit uses `Start | Busy` to stall any multiply/divide-class instruction sitting in D.

## Interface
- `MULT_CYCLES`, 5, Busy cycles for mult/multu (1..15)
- `DIV_CYCLES`, 10, Busy cycles for div/divu (1..15)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- `Start`  in  1  E-stage instruction is MD-class this cycle (qualifies `MDOp`)
- `MDOp`  in  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 no-op
- `A`  in  32  forwarded rs value (E stage)
- `B`  in  32  forwarded rt value (E stage)
- `Busy`  out  1  registered; high while an op is in flight
- `HI`  out  32  architectural HI register
- `LO`  out  32  architectural LO register

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`; 64-bit pending result `{pHI,pLO}`.
- IDLE, `Start` with MDOp 1..4: compute result from `A`,`B` combinationally, latch into pending, load `cnt` = MULT_CYCLES or DIV_CYCLES, go BUSY. HI/LO unchanged.
- IDLE, `Start` with MDOp 5: HI <= A; MDOp 6: LO <= A; stay IDLE, Busy stays 0.
- IDLE, `Start` with MDOp 0/7, or `Start`=0: no state change.
- BUSY: `cnt` decrements each cycle; on the edge where `cnt`==1: HI <= pHI, LO <= pLO, go IDLE.
- `Start` while BUSY (any MDOp): ignored; pending op completes unchanged. Hazard unit must prevent this; bench flags it as a protocol error but DUT must not corrupt state.
- mult: signed 32x32 -> 64, {HI,LO} = A*B. multu: unsigned.
- div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend (A). divu: unsigned.
- Divide by zero (B==0, div/divu): full DIV_CYCLES busy period, HI/LO left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (no trap).
- `reset`: state IDLE, `cnt`=0, Busy=0, HI=0, LO=0, pending cleared; reset during BUSY aborts the op, no HI/LO write. Reset wins over a simultaneous `Start`.

## Timing
- Reset values: Busy 0, HI 0x00000000, LO 0x00000000.
- Start of mult/div sampled at edge ending cycle T. Busy high cycles T+1 .. T+N (N = MULT_CYCLES/DIV_CYCLES), exactly N cycles.
- HI/LO written on the edge ending cycle T+N; new values visible in cycle T+N+1, same cycle Busy is first low.
- A new `Start` may be accepted in cycle T+N+1 (back-to-back with 1-cycle gap from Busy fall is not required; zero gap allowed).
- mthi/mtlo: HI/LO visible the cycle after `Start`; Busy never asserted.
- `A`,`B`,`MDOp` sampled only in the `Start` cycle; later changes have no effect.
- `HI`,`LO`,`Busy` are pure register outputs; no combinational path from inputs.

## Test plan
- Reset then idle 3 cycles -> Busy=0, HI=0, LO=0 throughout.
- mult A=0xFFFFFFFE (-2), B=3 at cycle 0 -> Busy high cycles 1..5, cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy cycles 1..10, cycle 11: LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7,B=2 -> LO=3, HI=1.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> HI=0x12345678 from cycle 1, LO=0x9ABCDEF0 from cycle 2, Busy always 0; then div by B=0 -> 10 busy cycles, HI/LO unchanged.
- mult started, `Start`+mthi A=0xDEADBEEF asserted during cycle 3 of Busy -> ignored; final HI/LO equal the mult result, Busy timing unchanged.
- divu started, reset asserted in cycle 4 of Busy -> next cycle Busy=0, HI=0, LO=0; no late write at cycle 11.

Source files
------------

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - E-stage request and HI/LO result bundle for the multiply/divide unit
interface mdu_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - Multi-cycle multiply/divide unit holding the HI/LO registers
// Results are computed in the Start cycle and held pending until the latency counter expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_skip;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [63:0]        res;
  logic [3:0]         load;
  logic               skip;
  logic               is_long;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
  always_comb begin
    prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u = {32'd0, md.A} * {32'd0, md.B};

    b_safe = (md.B == 32'd0) ? 32'd1 : md.B;
    a_mag  = md.A[31] ? (~md.A + 32'd1) : md.A;
    b_mag  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    q_s    = (md.A[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = md.A[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = md.A / b_safe;
    r_u    = md.A % b_safe;

    res     = 64'd0;
    load    = 4'd0;
    skip    = 1'b0;
    is_long = 1'b0;
    case (md.MDOp)
      OP_MULT: begin
        res     = prod_s;
        load    = MULT_LOAD;
        is_long = 1'b1;
      end
      OP_MULTU: begin
        res     = prod_u;
        load    = MULT_LOAD;
        is_long = 1'b1;
      end
      OP_DIV: begin
        res     = {r_s, q_s};
        load    = DIV_LOAD;
        skip    = (md.B == 32'd0);
        is_long = 1'b1;
      end
      OP_DIVU: begin
        res     = {r_u, q_u};
        load    = DIV_LOAD;
        skip    = (md.B == 32'd0);
        is_long = 1'b1;
      end
      default: begin
        res     = 64'd0;
        load    = 4'd0;
        skip    = 1'b0;
        is_long = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_skip <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else if (state == S_IDLE) begin
      if (md.Start) begin
        if (md.MDOp == OP_MTHI) begin
          hi_q <= md.A;
        end else if (md.MDOp == OP_MTLO) begin
          lo_q <= md.A;
        end else if (is_long) begin
          p_hi   <= res[63:32];
          p_lo   <= res[31:0];
          p_skip <= skip;
          cnt    <= load;
          state  <= S_BUSY;
        end
      end
    end else begin
      // Start is deliberately not looked at here; the in-flight op always completes intact.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (!p_skip) begin
          hi_q <= p_hi;
          lo_q <= p_lo;
        end
        state <= S_IDLE;
      end
    end
  end

  assign md.Busy = (state == S_BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - Directed plus randomized bench for mdu against an arithmetic reference model
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_if bus();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic busy_exp);
    check({tag, " busy"}, {31'd0, bus.Busy}, {31'd0, busy_exp});
    check({tag, " hi"}, bus.HI, exp_hi);
    check({tag, " lo"}, bus.LO, exp_lo);
  endtask

  // Issue one op and follow it cycle by cycle; optionally inject a Start during Busy or a reset.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intrude_at, input int reset_at);
    logic [31:0] nhi, nlo;
    logic [63:0] p;
    longint sa, sb, q, r;
    int n;
    nhi = exp_hi;
    nlo = exp_lo;
    n   = 0;
    sa  = $signed(a);
    sb  = $signed(b);
    case (op)
      3'd1: begin p = sa * sb; nhi = p[63:32]; nlo = p[31:0]; n = MC; end
      3'd2: begin p = 64'(a) * 64'(b); nhi = p[63:32]; nlo = p[31:0]; n = MC; end
      3'd3: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
      end
      3'd4: begin
        n = DC;
        if (b != 0) begin nlo = a / b; nhi = a % b; end
      end
      3'd5: nhi = a;
      3'd6: nlo = a;
      default: n = 0;
    endcase

    bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
    step();
    bus.Start = 1'b0; bus.MDOp = 3'($urandom); bus.A = $urandom; bus.B = $urandom;

    if (n == 0) begin
      exp_hi = nhi;
      exp_lo = nlo;
      check_all($sformatf("op%0d short", op), 1'b0);
      return;
    end

    for (int k = 1; k <= n; k++) begin
      check_all($sformatf("op%0d busy c%0d", op, k), 1'b1);
      if (k == reset_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_all($sformatf("op%0d after reset", op), 1'b0);
        for (int j = k + 1; j <= n + 1; j++) begin
          step();
          check_all($sformatf("op%0d no late write c%0d", op, j + 1), 1'b0);
        end
        return;
      end
      if (k == intrude_at) begin
        $display("note: protocol violation injected, Start during Busy at cycle %0d", k);
        bus.Start = 1'b1; bus.MDOp = 3'd5; bus.A = 32'hDEADBEEF;
      end
      step();
      bus.Start = 1'b0;
    end
    exp_hi = nhi;
    exp_lo = nlo;
    check_all($sformatf("op%0d done", op), 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1;
    bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("reset idle %0d", i), 1'b0);
      step();
    end

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("mult const hi", bus.HI, 32'hFFFFFFFF);
    check("mult const lo", bus.LO, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("multu const hi", bus.HI, 32'h00000002);
    check("multu const lo", bus.LO, 32'hFFFFFFFA);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div const hi", bus.HI, 32'hFFFFFFFF);
    check("div const lo", bus.LO, 32'hFFFFFFFD);
    run_op(3'd4, 32'd7, 32'd2, 0, 0);
    check("divu const hi", bus.HI, 32'd1);
    check("divu const lo", bus.LO, 32'd3);

    run_op(3'd5, 32'h12345678, 32'd0, 0, 0);
    run_op(3'd6, 32'h9ABCDEF0, 32'd0, 0, 0);
    check("mthi const", bus.HI, 32'h12345678);
    check("mtlo const", bus.LO, 32'h9ABCDEF0);
    run_op(3'd3, 32'h00001234, 32'd0, 0, 0);
    check("div0 hi kept", bus.HI, 32'h12345678);
    check("div0 lo kept", bus.LO, 32'h9ABCDEF0);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("divovf const hi", bus.HI, 32'd0);
    check("divovf const lo", bus.LO, 32'h80000000);

    run_op(3'd1, 32'h00012345, 32'hFFFF6789, 3, 0);
    run_op(3'd4, 32'hCAFEF00D, 32'd17, 0, 4);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b, 0, 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        check_all($sformatf("rand gap %0d", i), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
